console_tx_arbiter: RTL
=======================

# console_tx_arbiter

Shares the single console `uart_tx` transmitter between two byte sources: port 0, the CPU console (XBUF writes), and port 1, the on-board monitor/debug message source. Each port has a small FIFO. A line-lock scheduler keeps each port's text lines unbroken, so CPU output and monitor output never interleave mid-line. The block sits between the memory-mapped console register logic and `uart_tx`, and drives `tx_data`/`tx_send` in place of the direct XBUF path.

## Interface
- `FIFO_DEPTH`, default 4: entries per port FIFO; must be a power of 2, minimum 2.
- `LOCK_TIMEOUT`, default 2_700_000: idle cycles after which a held line-lock is released (100 ms at 27 MHz).
- `EOL_CHAR`, default 8'h0A: byte that ends a line and releases the lock after it is sent.
- `sys_clk` in 1: system clock, 27 MHz.
- `RESET_n` in 1: asynchronous, active-low reset.
- `wr0` in 1: port 0 (CPU) write strobe, one cycle per byte.
- `data0` in 8: port 0 byte.
- `ready0` out 1: port 0 FIFO not full; this is the source for XCSR bit 7.
- `wr1` in 1: port 1 (monitor) write strobe.
- `data1` in 8: port 1 byte.
- `ready1` out 1: port 1 FIFO not full.
- `ovf` out 2: sticky overflow flags, bit n set when `wrn` is asserted while port n is full.
- `tx_ready` in 1: from `uart_tx`; high when the transmitter is idle.
- `tx_send` out 1: to `uart_tx`; send request.
- `tx_data` out 8: to `uart_tx`; byte to send.
- `owner` out 2: debug only. 00 = no lock, 01 = port 0 holds the lock, 10 = port 1 holds the lock.

## Operation
- **FIFOs:** one per port, circular, with a count of width log2(FIFO_DEPTH)+1.
  - A write is accepted when `wrn` is high and count < FIFO_DEPTH, judged on the pre-edge count.
  - A write to a full FIFO is dropped and sets `ovf[n]`, even if a pop happens in the same cycle.
  - A simultaneous accepted push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **`readyn`:** combinational, equal to (count != FIFO_DEPTH).
- **State machine:**
  - IDLE: `tx_send` = 0. Waits until `tx_ready` = 1 and a port is selected. On selection it pops that port's head into `tx_data`, sets `tx_send` = 1 and moves to SEND.
  - SEND: `tx_send` = 1 and `tx_data` is held. When `tx_ready` = 0 it clears `tx_send` and moves to WAIT.
  - WAIT: waits for `tx_ready` = 1, then returns to IDLE.
- **Selection (in IDLE):**
  - If a port holds the lock, only the owner may be selected. The other port is never served while the lock is held, even if the owner's FIFO is empty.
  - With no lock, round-robin between non-empty ports. The port not served last wins a tie; after reset port 0 wins.
- **Lock rules:**
  - Granting a byte that is not EOL_CHAR sets `owner` to that port.
  - Granting a byte equal to EOL_CHAR clears `owner` at the same edge.
- **Lock timeout:**
  - The lock timer counts cycles where the state is IDLE, `owner` != 00 and the owner's FIFO is empty.
  - It clears on every grant and whenever that condition is false.
  - When the timer reaches LOCK_TIMEOUT, `owner` clears to 00 and the timer clears.
- **Reset (asynchronous):**
  - State = IDLE, `tx_send` = 0, `tx_data` = 8'h00, `owner` = 00, `ovf` = 00.
  - FIFOs are emptied, so `ready0` = `ready1` = 1.
  - The round-robin pointer is set to favour port 0 and the lock timer is cleared.
  - A byte in flight is abandoned.

## Timing
- **Write to visible:** a byte written at edge k is eligible for selection at edge k+1.
  - With an empty system and `tx_ready` = 1, `tx_send` rises at edge k+1 and is visible in cycle k+1.
- **tx_send hold:** `tx_send` stays high at least until the first edge at which `tx_ready` = 0 is sampled, then falls at that edge.
- **tx_data stability:** `tx_data` changes only on the IDLE→SEND transition.
- **Back-to-back:** the next byte is not issued until WAIT has seen `tx_ready` = 1 and IDLE has spent one cycle.
- **Lock update:** `owner` updates on the same edge as the IDLE→SEND transition.
- **Timeout release:** occurs at the edge where the timer equals LOCK_TIMEOUT. Selection may happen at the following edge.

## Test plan
- **Single byte:** reset, then write `data0` = 8'h41 with `uart_tx` idle → `tx_send` high one cycle later with `tx_data` = 8'h41; `tx_send` falls on the first cycle `tx_ready` is low; `owner` = 01.
- **Line-lock:** port 0 writes "AB" (no EOL), port 1 writes "xy\n", port 0 later writes "\n" → TX order A, B, \n, x, y, \n; `owner` = 00 after each \n.
- **Round-robin:** no lock, both ports write EOL_CHAR-only bytes continuously → the ports alternate 0, 1, 0, 1.
- **Overflow:** hold `tx_ready` = 0 and write 5 bytes to port 1 with FIFO_DEPTH = 4 → `ready1` = 0 after the 4th write, the 5th byte is dropped, `ovf` = 10 and stays set until reset.
- **Timeout:** LOCK_TIMEOUT = 16; port 0 sends "A" then stops, port 1 has a byte queued → port 1 is granted exactly after 16 IDLE cycles with port 0 empty.
- **Reset mid-send:** assert `RESET_n` = 0 while in SEND → `tx_send` = 0 and `tx_data` = 00 immediately (asynchronous); FIFOs are empty and both ready outputs are 1.

Source files
------------

// File: rtl/console_tx_arbiter_if.sv
// Console transmit arbiter bus: two byte-source ports, the uart_tx handshake and status.
// The slave modport is the arbiter; the master modport is the side that drives the sources.
interface console_tx_arbiter_if;
  logic       wr0;
  logic [7:0] data0;
  logic       ready0;
  logic       wr1;
  logic [7:0] data1;
  logic       ready1;
  logic [1:0] ovf;
  logic       tx_ready;
  logic       tx_send;
  logic [7:0] tx_data;
  logic [1:0] owner;

  modport master (
    output wr0, data0, wr1, data1, tx_ready,
    input  ready0, ready1, ovf, tx_send, tx_data, owner
  );

  modport slave (
    input  wr0, data0, wr1, data1, tx_ready,
    output ready0, ready1, ovf, tx_send, tx_data, owner
  );
endinterface

// File: rtl/console_tx_arbiter.sv
// Shares one uart_tx between the CPU console (port 0) and the monitor (port 1), keeping
// each port's text lines unbroken through a line-lock held until EOL or an idle timeout.
module console_tx_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned LOCK_TIMEOUT = 2_700_000,
  parameter logic [7:0]  EOL_CHAR     = 8'h0A
) (
  input logic                 sys_clk,
  input logic                 RESET_n,
  console_tx_arbiter_if.slave bus
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

  logic [7:0]           mem_q [2][FIFO_DEPTH];
  logic [1:0][PW-1:0]   wptr_q, rptr_q;
  logic [1:0][CW-1:0]   count_q;
  logic [1:0][7:0]      wdata;
  logic [1:0]           wr, push, pop, full, nonempty;
  logic [1:0]           ovf_q;

  state_e               state_q;
  logic                 tx_send_q;
  logic [7:0]           tx_data_q;
  logic [1:0]           owner_q;
  logic                 rr_q;
  logic [TW-1:0]        timer_q;

  logic                 sel, sel_valid, grant, lock_cond;
  logic [7:0]           head;

  always_comb begin
    wr    = {bus.wr1, bus.wr0};
    wdata = {bus.data1, bus.data0};
    for (int n = 0; n < 2; n++) begin
      full[n]     = (count_q[n] == CW'(FIFO_DEPTH));
      nonempty[n] = (count_q[n] != '0);
      push[n]     = wr[n] & ~full[n];
    end
  end

  // A held lock restricts selection to the owner, even while its FIFO is empty.
  always_comb begin
    sel       = 1'b0;
    sel_valid = 1'b0;
    if (owner_q[0]) begin
      sel       = 1'b0;
      sel_valid = nonempty[0];
    end else if (owner_q[1]) begin
      sel       = 1'b1;
      sel_valid = nonempty[1];
    end else if (&nonempty) begin
      sel       = rr_q;
      sel_valid = 1'b1;
    end else begin
      sel       = nonempty[1];
      sel_valid = |nonempty;
    end
    grant     = (state_q == StIdle) && bus.tx_ready && sel_valid;
    pop       = '0;
    pop[sel]  = grant;
    head      = mem_q[sel][rptr_q[sel]];
    lock_cond = (state_q == StIdle) && (owner_q != 2'b00) &&
                (owner_q[0] ? !nonempty[0] : !nonempty[1]);
  end

  always_ff @(posedge sys_clk) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) mem_q[n][wptr_q[n]] <= wdata[n];
    end
  end

  // Fullness is judged on the pre-edge count, so a same-cycle pop never rescues a write.
  always_ff @(posedge sys_clk or negedge RESET_n) begin
    if (!RESET_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (push[n]) wptr_q[n] <= wptr_q[n] + 1'b1;
        if (pop[n])  rptr_q[n] <= rptr_q[n] + 1'b1;
        if (push[n] && !pop[n])      count_q[n] <= count_q[n] + 1'b1;
        else if (!push[n] && pop[n]) count_q[n] <= count_q[n] - 1'b1;
        if (wr[n] && full[n]) ovf_q[n] <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= StIdle;
      tx_send_q <= 1'b0;
      tx_data_q <= 8'h00;
      owner_q   <= 2'b00;
      rr_q      <= 1'b0;
      timer_q   <= '0;
    end else begin
      timer_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            tx_data_q <= head;
            tx_send_q <= 1'b1;
            state_q   <= StSend;
            owner_q   <= (head == EOL_CHAR) ? 2'b00 : (sel ? 2'b10 : 2'b01);
            rr_q      <= ~sel;
          end else if (lock_cond) begin
            if (timer_q == TW'(LOCK_TIMEOUT)) owner_q <= 2'b00;
            else                             timer_q <= timer_q + 1'b1;
          end
        end
        StSend: begin
          if (!bus.tx_ready) begin
            tx_send_q <= 1'b0;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (bus.tx_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready0  = ~full[0];
  assign bus.ready1  = ~full[1];
  assign bus.ovf     = ovf_q;
  assign bus.tx_send = tx_send_q;
  assign bus.tx_data = tx_data_q;
  assign bus.owner   = owner_q;

endmodule
